tt_um_count_monitor_shivam: RTL and testbench

Receive-side companion to the team's up/down counter tile: samples an 8-bit count stream on `ui_in` (wired to a counter's `uo_out`) and decodes each step as up, down, hold or jump. Tracks lock state, run length, direction reversals and step errors, and exposes them through a selectable 8-bit view on `uo_out` plus per-step pulse flags on `uio_out[7:4]`. Sits at the far end of the counter's output bus as a checker and monitor.

---
 rtl/tt_um_count_monitor_shivam.sv | 151 +++++++++++++++
 tb/tb_tt_um_count_monitor_shivam.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_count_monitor_shivam.sv
// Count-stream monitor: watches a counter's 8-bit output, classifies every
// step as up/down/hold/jump and keeps lock, run-length, reversal and error
// statistics, exposed through a selectable 8-bit view plus per-step pulses.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_INIT   | no reference value yet; next sample only loads prev
// ST_LOCKED | last step was up/down/hold, stream looks like a counter
// ST_LOST   | last step was a jump, waiting for a well-formed step
module tt_um_count_monitor_shivam (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {ST_INIT, ST_LOCKED, ST_LOST} state_t;
   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;
   // Encoding doubles as the pulse bit index (hold, up, down, jump).
   typedef enum logic [1:0] {CLS_HOLD, CLS_UP, CLS_DOWN, CLS_JUMP} cls_t;

   logic       sample_en;
   logic [1:0] view_sel;
   logic       clear;
   logic       unused_uio;

   assign sample_en  = uio_in[0];
   assign view_sel   = uio_in[2:1];
   assign clear      = uio_in[3];
   assign unused_uio = &uio_in[7:4];

   state_t     state_q, state_d;
   dir_t       last_dir_q, last_dir_d;
   cls_t       last_cls_q, last_cls_d;
   logic       last_cls_vld_q, last_cls_vld_d;
   logic [7:0] prev_q, prev_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] run_len_q, run_len_d;
   logic [7:0] rev_cnt_q, rev_cnt_d;
   logic [3:0] pulse_q, pulse_d;

   logic [7:0] delta;
   cls_t       cls;

   // Step decode from the modular difference; wrap-around is a legal step.
   always_comb begin
      delta = ui_in - prev_q;
      case (delta)
         8'h00:   cls = CLS_HOLD;
         8'h01:   cls = CLS_UP;
         8'hFF:   cls = CLS_DOWN;
         default: cls = CLS_JUMP;
      endcase
   end

   // Next-state, statistics and pulse computation.
   always_comb begin
      state_d        = state_q;
      last_dir_d     = last_dir_q;
      last_cls_d     = last_cls_q;
      last_cls_vld_d = last_cls_vld_q;
      prev_d         = prev_q;
      err_cnt_d      = err_cnt_q;
      run_len_d      = run_len_q;
      rev_cnt_d      = rev_cnt_q;
      pulse_d        = 4'b0000;
      if (ena) begin
         if (clear) begin
            state_d        = ST_INIT;
            last_dir_d     = DIR_NONE;
            last_cls_vld_d = 1'b0;
            err_cnt_d      = 8'h00;
            run_len_d      = 8'h00;
            rev_cnt_d      = 8'h00;
         end else if (sample_en) begin
            prev_d = ui_in;
            if (state_q == ST_INIT) begin
               state_d = ST_LOCKED;
            end else begin
               pulse_d = 4'b0001 << cls;
               if (cls == CLS_JUMP) begin
                  state_d    = ST_LOST;
                  last_dir_d = DIR_NONE;
                  run_len_d  = 8'h00;
                  err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
               end else begin
                  state_d        = ST_LOCKED;
                  last_cls_d     = cls;
                  last_cls_vld_d = 1'b1;
                  if (last_cls_vld_q && (last_cls_q == cls))
                     run_len_d = (run_len_q == 8'hFF) ? run_len_q : run_len_q + 8'd1;
                  else
                     run_len_d = 8'h01;
                  if (cls == CLS_UP) begin
                     if (last_dir_q == DIR_DOWN)
                        rev_cnt_d = (rev_cnt_q == 8'hFF) ? rev_cnt_q : rev_cnt_q + 8'd1;
                     last_dir_d = DIR_UP;
                  end else if (cls == CLS_DOWN) begin
                     if (last_dir_q == DIR_UP)
                        rev_cnt_d = (rev_cnt_q == 8'hFF) ? rev_cnt_q : rev_cnt_q + 8'd1;
                     last_dir_d = DIR_DOWN;
                  end
               end
            end
         end
      end
   end

   // Register update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_INIT;
         last_dir_q     <= DIR_NONE;
         last_cls_q     <= CLS_HOLD;
         last_cls_vld_q <= 1'b0;
         prev_q         <= 8'h00;
         err_cnt_q      <= 8'h00;
         run_len_q      <= 8'h00;
         rev_cnt_q      <= 8'h00;
         pulse_q        <= 4'b0000;
      end else begin
         state_q        <= state_d;
         last_dir_q     <= last_dir_d;
         last_cls_q     <= last_cls_d;
         last_cls_vld_q <= last_cls_vld_d;
         prev_q         <= prev_d;
         err_cnt_q      <= err_cnt_d;
         run_len_q      <= run_len_d;
         rev_cnt_q      <= rev_cnt_d;
         pulse_q        <= pulse_d;
      end
   end

   // View mux straight off the registers so view_sel acts in the same cycle.
   always_comb begin
      case (view_sel)
         2'b00:   uo_out = prev_q;
         2'b01:   uo_out = err_cnt_q;
         2'b10:   uo_out = run_len_q;
         default: uo_out = rev_cnt_q;
      endcase
   end

   assign uio_out = {pulse_q, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_count_monitor_shivam.sv
`timescale 1ns/100ps
module tb_tt_um_count_monitor_shivam;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   int total = 0;
   int bad = 0;

   tt_um_count_monitor_shivam dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #10 clk = ~clk;

   // Reference model: spec rules in plain arithmetic.
   bit  m_need_init;
   int  m_prev, m_err, m_run, m_rev;
   int  m_last_dir;   // 0 none, 1 up, -1 down
   int  m_last_cls;   // -1 none, 0 hold, 1 up, 2 down
   int  m_pulse;      // -1 none, else class 0..3 (hold, up, down, jump)

   function automatic int sat(input int x);
      return (x > 255) ? 255 : x;
   endfunction

   task automatic model_reset();
      m_need_init = 1; m_prev = 0; m_err = 0; m_run = 0; m_rev = 0;
      m_last_dir = 0; m_last_cls = -1; m_pulse = -1;
   endtask

   task automatic model_edge(input bit r, input bit e, input bit s, input bit c, input int u);
      int d, cls;
      if (!r) begin
         model_reset();
      end else if (!e) begin
         m_pulse = -1;
      end else if (c) begin
         m_err = 0; m_run = 0; m_rev = 0; m_last_dir = 0; m_last_cls = -1;
         m_pulse = -1; m_need_init = 1;
      end else if (!s) begin
         m_pulse = -1;
      end else if (m_need_init) begin
         m_prev = u; m_need_init = 0; m_pulse = -1;
      end else begin
         d = (u - m_prev + 256) % 256;
         cls = (d == 0) ? 0 : (d == 1) ? 1 : (d == 255) ? 2 : 3;
         m_pulse = cls;
         m_prev = u;
         if (cls == 3) begin
            m_err = sat(m_err + 1); m_run = 0; m_last_dir = 0;
         end else begin
            m_run = (cls == m_last_cls) ? sat(m_run + 1) : 1;
            m_last_cls = cls;
            if (cls == 1) begin
               if (m_last_dir == -1) m_rev = sat(m_rev + 1);
               m_last_dir = 1;
            end else if (cls == 2) begin
               if (m_last_dir == 1) m_rev = sat(m_rev + 1);
               m_last_dir = -1;
            end
         end
      end
   endtask

   function automatic logic [7:0] m_view(input int v);
      case (v)
         0: return m_prev[7:0];
         1: return m_err[7:0];
         2: return m_run[7:0];
         default: return m_rev[7:0];
      endcase
   endfunction

   function automatic logic [7:0] m_uio();
      logic [7:0] r;
      r = 8'h00;
      if (m_pulse >= 0) r[4 + m_pulse] = 1'b1;
      return r;
   endfunction

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs at the falling edge, advance the model at the rising edge.
   task automatic step(input bit r, input bit e, input bit s, input bit c,
                       input logic [7:0] u, input logic [1:0] vs);
      @(negedge clk);
      rst_n = r; ena = e; ui_in = u;
      uio_in = {4'($urandom_range(0, 15)), c, vs, s};
      @(posedge clk);
      model_edge(r, e, s, c, int'(u));
      #1;
   endtask

   // Sweep every view and the pulse byte against the model.
   task automatic check_all(input string tag);
      for (int v = 0; v < 4; v++) begin
         uio_in[2:1] = 2'(v);
         #1;
         cmp($sformatf("%s_view%0d", tag, v), uo_out, m_view(v));
      end
      cmp({tag, "_uio"}, uio_out, m_uio());
      cmp({tag, "_oe"}, uio_oe, 8'hF0);
   endtask

   typedef struct {
      bit         r, e, s, c;
      logic [7:0] ui;
      logic [1:0] vs;
      logic [7:0] exp_uo;
      logic [7:0] exp_uio;
   } vec_t;

   vec_t vecs[$];

   initial begin
      model_reset();
      // reset, 05 06 07 with run_len view
      vecs.push_back('{0,1,0,0,8'h00,2'b10,8'h00,8'h00});
      vecs.push_back('{1,1,1,0,8'h05,2'b10,8'h00,8'h00});
      vecs.push_back('{1,1,1,0,8'h06,2'b10,8'h01,8'h20});
      vecs.push_back('{1,1,1,0,8'h07,2'b10,8'h02,8'h20});
      vecs.push_back('{1,1,0,0,8'h33,2'b00,8'h07,8'h00});
      // clear with a same-cycle sample; prev holds
      vecs.push_back('{1,1,1,1,8'h99,2'b00,8'h07,8'h00});
      // FE FF 00 FF: init, up, up (wrap), down -> one reversal
      vecs.push_back('{1,1,1,0,8'hFE,2'b11,8'h00,8'h00});
      vecs.push_back('{1,1,1,0,8'hFF,2'b11,8'h00,8'h20});
      vecs.push_back('{1,1,1,0,8'h00,2'b11,8'h00,8'h20});
      vecs.push_back('{1,1,1,0,8'hFF,2'b11,8'h01,8'h40});
      // clear, 10 20 21: jump then up
      vecs.push_back('{1,1,0,1,8'h00,2'b01,8'h00,8'h00});
      vecs.push_back('{1,1,1,0,8'h10,2'b01,8'h00,8'h00});
      vecs.push_back('{1,1,1,0,8'h20,2'b01,8'h01,8'h80});
      vecs.push_back('{1,1,1,0,8'h21,2'b10,8'h01,8'h20});
      // clear, 03 04 04 03: up, hold, down; hold keeps the reversal
      vecs.push_back('{1,1,0,1,8'h00,2'b11,8'h00,8'h00});
      vecs.push_back('{1,1,1,0,8'h03,2'b11,8'h00,8'h00});
      vecs.push_back('{1,1,1,0,8'h04,2'b11,8'h00,8'h20});
      vecs.push_back('{1,1,1,0,8'h04,2'b11,8'h00,8'h10});
      vecs.push_back('{1,1,1,0,8'h03,2'b11,8'h01,8'h40});
      // ena low for 3 cycles while ui_in moves
      vecs.push_back('{1,0,1,0,8'h50,2'b00,8'h03,8'h00});
      vecs.push_back('{1,0,1,0,8'h77,2'b11,8'h01,8'h00});
      vecs.push_back('{1,0,1,1,8'h78,2'b10,8'h01,8'h00});
      vecs.push_back('{1,1,1,0,8'h02,2'b10,8'h02,8'h40});
      // mid-stream reset, then the next sample is an init sample
      vecs.push_back('{0,1,1,0,8'h40,2'b00,8'h00,8'h00});
      vecs.push_back('{1,1,1,0,8'h41,2'b00,8'h41,8'h00});
      vecs.push_back('{1,1,1,0,8'h42,2'b10,8'h01,8'h20});

      repeat (2) @(posedge clk);
      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].c, vecs[i].ui, vecs[i].vs);
         cmp($sformatf("vec%0d_uo", i), uo_out, vecs[i].exp_uo);
         cmp($sformatf("vec%0d_uio", i), uio_out, vecs[i].exp_uio);
         check_all($sformatf("vec%0d", i));
      end

      // Error counter saturation: 300 jumps
      step(1, 1, 0, 1, 8'h00, 2'b01);
      for (int i = 0; i < 301; i++) step(1, 1, 1, 0, (i % 2) ? 8'h80 : 8'h00, 2'b01);
      cmp("err_sat", uo_out, 8'hFF);
      check_all("err_sat");
      // clear together with sample_en: counters zero, no pulse
      step(1, 1, 1, 1, 8'h81, 2'b01);
      cmp("clr_err", uo_out, 8'h00);
      cmp("clr_uio", uio_out, 8'h00);
      check_all("clr");
      step(1, 1, 1, 0, 8'h81, 2'b10);
      cmp("post_clr_init_uio", uio_out, 8'h00);
      check_all("post_clr");

      // run_len saturation: 300 holds
      for (int i = 0; i < 300; i++) step(1, 1, 1, 0, 8'h81, 2'b10);
      cmp("run_sat", uo_out, 8'hFF);
      check_all("run_sat");

      // rev_cnt saturation: alternate up/down
      for (int i = 0; i < 300; i++) step(1, 1, 1, 0, (i % 2) ? 8'h81 : 8'h82, 2'b11);
      cmp("rev_sat", uo_out, 8'hFF);
      check_all("rev_sat");

      // Randomized stream biased toward legal steps
      for (int i = 0; i < 2000; i++) begin
         int k;
         logic [7:0] u;
         k = $urandom_range(0, 9);
         case (k)
            0, 1, 2: u = 8'(m_prev + 1);
            3, 4:    u = 8'(m_prev - 1);
            5, 6:    u = 8'(m_prev);
            default: u = 8'($urandom_range(0, 255));
         endcase
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 4) != 0), ($urandom_range(0, 39) == 0),
              u, 2'($urandom_range(0, 3)));
         check_all("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
